// File: rtl/mips32_pkg.sv
// Shared opcode/funct encodings, ALU operation enum and the ALU helper for mips32_top.
package mips32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  typedef enum logic [2:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mips32_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port, R0 hardwired to 0.
module mips32_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && wa != 5'd0) begin
      registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];

endmodule

// File: rtl/mips32_top.sv
// Single-cycle MIPS32-subset CPU with inline instruction/data memories and control.
// Optional MIPS32_TRACE_EN: simulation-only per-instruction trace of PC, instruction and writes.
module mips32_top
  import mips32_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic clk,
  input  logic reset,
  output logic halted
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0] instr_addr, instr_from_mem;
  logic [31:0] rs_val, rt_val, simm, ea, alu_res, wb_data, dmem_rdata, pc4, pc_next;
  logic [4:0]  wa;
  logic [DAW-1:0] dmem_idx;
  logic        dec_we, reg_we, mem_we, use_imm;
  logic        is_lw, is_sw, is_beq, is_bne, is_j, is_halt;
  alu_op_t     alu_op;

  wire [5:0] opcode = instr_from_mem[31:26];
  wire [4:0] rs     = instr_from_mem[25:21];
  wire [4:0] rt     = instr_from_mem[20:16];
  wire [4:0] rd     = instr_from_mem[15:11];
  wire [5:0] funct  = instr_from_mem[5:0];

  // Named blocks give the bench stable hierarchical paths to the arrays.
  if (1) begin : code_memory
    logic [31:0] instr_mem [0:IMEM_DEPTH-1];
    assign instr_from_mem = (instr_addr[31:2] < 30'(IMEM_DEPTH)) ?
                            instr_mem[instr_addr[IAW+1:2]] : HALT_WORD;
  end

  if (1) begin : Data_Memory
    logic [31:0] data_memory [0:DMEM_DEPTH-1];
    assign dmem_rdata = data_memory[dmem_idx];
    always_ff @(posedge clk) begin
      if (mem_we) data_memory[dmem_idx] <= rt_val;
    end
  end

  mips32_regfile register_file (
    .clk(clk), .rst_n(reset), .we(reg_we), .ra1(rs), .ra2(rt), .wa(wa),
    .wd(wb_data), .rd1(rs_val), .rd2(rt_val)
  );

  always_comb begin
    alu_op  = ALU_NOP;
    dec_we  = 1'b0;
    wa      = rd;
    use_imm = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_we = 1'b1;
        case (funct)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_SLT:   alu_op = ALU_SLT;
          default: dec_we = 1'b0;
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; dec_we = 1'b1; wa = rt; use_imm = 1'b1; end
      OP_SUBI: begin alu_op = ALU_SUB; dec_we = 1'b1; wa = rt; use_imm = 1'b1; end
      OP_LW:   begin is_lw = 1'b1; dec_we = 1'b1; wa = rt; end
      OP_SW:   is_sw   = 1'b1;
      OP_BEQ:  is_beq  = 1'b1;
      OP_BNE:  is_bne  = 1'b1;
      OP_J:    is_j    = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign simm     = {{16{instr_from_mem[15]}}, instr_from_mem[15:0]};
  assign ea       = rs_val + simm;
  assign dmem_idx = DAW'(ea % 32'(DMEM_DEPTH));
  assign alu_res  = alu(alu_op, rs_val, use_imm ? simm : rt_val);
  assign wb_data  = is_lw ? dmem_rdata : alu_res;
  // Writes are suppressed once halted and while reset is held.
  assign reg_we   = dec_we && !halted;
  assign mem_we   = is_sw && !halted && reset;
  assign pc4      = instr_addr + 32'd4;

  always_comb begin
    pc_next = pc4;
    if ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val))
      pc_next = pc4 + {simm[29:0], 2'b00};
    else if (is_j)
      pc_next = {pc4[31:28], instr_from_mem[25:0], 2'b00};
    else if (is_halt)
      pc_next = instr_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_addr <= '0;
      halted     <= 1'b0;
    end else if (!halted) begin
      instr_addr <= pc_next;
      if (is_halt) halted <= 1'b1;
    end
  end

`ifdef MIPS32_TRACE_EN
  always @(posedge clk) begin
    if (reset && !halted) begin
      $display("%0t pc=%08h ins=%08h", $time, instr_addr, instr_from_mem);
      if (reg_we && wa != 5'd0) $display("  r%0d <= %08h", wa, wb_data);
      if (mem_we) $display("  mem[%0d] <= %08h", dmem_idx, rt_val);
    end
  end
`endif

endmodule

// File: tb/tb_mips32_top.sv
// Self-checking bench for mips32_top: directed programs plus random programs vs an ISA-level model.
module tb_mips32_top;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halted;
  int   n_chk = 0;
  int   n_err = 0;

  mips32_top #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .halted(halted)
  );

  always #5 clk = ~clk;

  // Architectural reference state.
  logic [31:0] m_imem [0:63];
  logic [31:0] m_dmem [0:63];
  logic [31:0] m_reg  [0:31];
  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] trace [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic m_wr(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 5'd0) m_reg[idx] = v;
  endtask

  // One instruction executed straight from the ISA rules.
  task automatic m_step();
    logic [31:0] ins, a, b, simm, npc;
    logic [4:0]  rs, rt, rd;
    if (m_halt) return;
    ins  = (m_pc / 4 < 64) ? m_imem[m_pc / 4] : 32'hFC00_0000;
    rs   = ins[25:21];
    rt   = ins[20:16];
    rd   = ins[15:11];
    simm = {{16{ins[15]}}, ins[15:0]};
    a    = m_reg[rs];
    b    = m_reg[rt];
    npc  = m_pc + 4;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: m_wr(rd, a + b);
        6'h22: m_wr(rd, a - b);
        6'h24: m_wr(rd, a & b);
        6'h25: m_wr(rd, a | b);
        6'h2A: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        default: ;
      endcase
      6'h08: m_wr(rt, a + simm);
      6'h09: m_wr(rt, a - simm);
      6'h23: m_wr(rt, m_dmem[(a + simm) % 64]);
      6'h2B: m_dmem[(a + simm) % 64] = b;
      6'h04: if (a == b) npc = npc + simm * 4;
      6'h05: if (a != b) npc = npc + simm * 4;
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h3F: begin m_halt = 1'b1; npc = m_pc; end
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) begin
      m_imem[i] = 32'hFC00_0000;
      dut.code_memory.instr_mem[i] = 32'hFC00_0000;
    end
  endtask

  task automatic put_ins(input int i, input logic [31:0] v);
    m_imem[i] = v;
    dut.code_memory.instr_mem[i] = v;
  endtask

  task automatic put_dat(input int i, input logic [31:0] v);
    m_dmem[i] = v;
    dut.Data_Memory.data_memory[i] <= v;
  endtask

  task automatic rand_dmem();
    for (int i = 0; i < 64; i++) put_dat(i, $urandom);
  endtask

  // Reset, then run in lockstep with the model until HALT or the cycle budget runs out.
  task automatic run_prog(input int max_cyc);
    int cyc;
    m_pc = 0;
    m_halt = 1'b0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    trace.delete();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", dut.instr_addr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    reset = 1'b1;
    cyc = 0;
    forever begin
      trace.push_back(dut.instr_addr);
      chk("pc", dut.instr_addr, m_pc);
      chk("halted", {31'b0, halted}, {31'b0, m_halt});
      if (m_halt) break;
      if (cyc >= max_cyc) begin
        chk("timeout_halt", {31'b0, halted}, 32'h1);
        break;
      end
      m_step();
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic cmp_state(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_r%0d", tag, i), dut.register_file.registers[i], m_reg[i]);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s_m%0d", tag, i), dut.Data_Memory.data_memory[i], m_dmem[i]);
  endtask

  function automatic logic [31:0] rnd_ins(input int idx);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  f;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1: begin
        case ($urandom_range(0, 5))
          0: f = 6'h20;
          1: f = 6'h22;
          2: f = 6'h24;
          3: f = 6'h25;
          4: f = 6'h2A;
          default: f = 6'($urandom_range(0, 63));
        endcase
        return {6'h00, rs, rt, rd, 5'd0, f};
      end
      2: return {6'h08, rs, rt, imm};
      3: return {6'h09, rs, rt, imm};
      4: return {6'h23, rs, rt, imm};
      5: return {6'h2B, rs, rt, imm};
      6: return {6'h04, rs, rt, 16'($urandom_range(0, 3))};
      7: return {6'h05, rs, rt, 16'($urandom_range(0, 3))};
      8: return {6'h02, 26'(idx + 1 + int'($urandom_range(0, 3)))};
      default: return {6'h0C, 26'($urandom)};
    endcase
  endfunction

  logic [31:0] sum_prog [0:9] = '{32'h20030000, 32'h2001000F, 32'h20020005, 32'h20210001,
                                  32'h8C240000, 32'h00641820, 32'h24420001, 32'h10400001,
                                  32'h08000003, 32'hFC000000};
  logic [31:0] br_prog [0:16] = '{32'h20010007, 32'h2002FFFD, 32'h10000001, 32'hFC000000,
                                  32'h14210005, 32'h08000007, 32'hFC000000, 32'h00221820,
                                  32'h00222022, 32'h00224824, 32'h00225025, 32'h0041382A,
                                  32'h00210020, 32'h20051234, 32'hAC050004, 32'h8C060004,
                                  32'hFC000000};

  initial begin
    // Summation loop.
    clear_imem();
    rand_dmem();
    for (int i = 0; i < 10; i++) put_ins(i, sum_prog[i]);
    put_dat(16, 32'd8); put_dat(17, 32'd8); put_dat(18, 32'd9);
    put_dat(19, 32'd9); put_dat(20, 32'd10);
    #1;
    run_prog(300);
    cmp_state("sum");
    chk("sum_r3", dut.register_file.registers[3], 32'd44);
    chk("sum_r1", dut.register_file.registers[1], 32'd20);
    chk("sum_r2", dut.register_file.registers[2], 32'd0);
    chk("sum_r4", dut.register_file.registers[4], 32'd10);
    chk("sum_pc", dut.instr_addr, 32'h24);
    chk("sum_halted", {31'b0, halted}, 32'h1);

    // Frozen while halted.
    repeat (10) @(negedge clk);
    chk("frz_pc", dut.instr_addr, 32'h24);
    chk("frz_halted", {31'b0, halted}, 32'h1);
    cmp_state("frz");

    // Asynchronous reset between clock edges clears state immediately.
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", dut.instr_addr, 32'h0);
    chk("arst_halted", {31'b0, halted}, 32'h0);
    chk("arst_r3", dut.register_file.registers[3], 32'h0);
    chk("arst_mem16", dut.Data_Memory.data_memory[16], 32'd8);
    run_prog(300);
    chk("rerun_r3", dut.register_file.registers[3], 32'd44);
    chk("rerun_pc", dut.instr_addr, 32'h24);

    // Reset mid-program, then re-execute from 0.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_pc", dut.instr_addr, 32'h0);
    chk("mid_r1", dut.register_file.registers[1], 32'h0);
    run_prog(300);
    chk("mid_rerun_r3", dut.register_file.registers[3], 32'd44);

    // Branches, jump, R-type, store/load.
    clear_imem();
    rand_dmem();
    for (int i = 0; i < 17; i++) put_ins(i, br_prog[i]);
    #1;
    run_prog(100);
    cmp_state("br");
    chk("beq_target", trace[3], 32'h10);
    chk("bne_fallthru", trace[4], 32'h14);
    chk("j_target", trace[5], 32'h1C);
    chk("add", dut.register_file.registers[3], 32'd4);
    chk("sub", dut.register_file.registers[4], 32'd10);
    chk("and", dut.register_file.registers[9], 32'd5);
    chk("or", dut.register_file.registers[10], 32'hFFFF_FFFF);
    chk("slt", dut.register_file.registers[7], 32'd1);
    chk("r0", dut.register_file.registers[0], 32'd0);
    chk("sw", dut.Data_Memory.data_memory[4], 32'h1234);
    chk("lw", dut.register_file.registers[6], 32'h1234);
    chk("br_pc", dut.instr_addr, 32'h40);

    // Jump outside instruction memory fetches HALT.
    clear_imem();
    put_ins(0, 32'h20010005);
    put_ins(1, 32'h08000064);
    run_prog(20);
    chk("oor_pc", dut.instr_addr, 32'h190);
    chk("oor_halted", {31'b0, halted}, 32'h1);
    chk("oor_r1", dut.register_file.registers[1], 32'd5);

    // Random programs.
    for (int t = 0; t < 6; t++) begin
      clear_imem();
      rand_dmem();
      for (int i = 0; i < 48; i++) put_ins(i, rnd_ins(i));
      #1;
      run_prog(200);
      cmp_state($sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mips32_top.md
Name: mips32_top

Overview:
- Single-cycle MIPS32-subset CPU: PC, instruction memory, register file, ALU, data memory and control, all in one block.
- Retires one instruction per clock, with no pipeline or stalls.
- Top-level simulation target; memories are loaded by the bench through hierarchical references.

Parameters:
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words.
- DMEM_DEPTH, 64, data memory depth in 32-bit words.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- halted  output  1  high once HALT has executed.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Required hierarchy for bench access:
  - instance code_memory with array instr_mem[0:IMEM_DEPTH-1];
  - instance Data_Memory with array data_memory[0:DMEM_DEPTH-1];
  - instance register_file with array registers[0:31];
  - top-level nets instr_addr (the PC) and instr_from_mem (the current instruction).
- Reset (reset=0, asynchronous):
  - PC=0, halted=0, all 32 registers=0.
  - Memories are NOT cleared, so bench preloads survive.
- Fetch:
  - instr_from_mem = instr_mem[PC[31:2]], combinational; PC is a byte address.
  - Out-of-range fetch returns 0xFC000000 (HALT).
- Register file:
  - Two combinational read ports, one write port on the clk edge.
  - R0 reads 0 always; writes to R0 are ignored.
- Data memory:
  - Word array indexed directly by the effective address (rs + sign-extended imm) modulo DMEM_DEPTH. There is no byte-lane shift.
  - Combinational read, synchronous write.
- Arithmetic: 32-bit, wrap-around, no overflow traps. Immediates are sign-extended unless noted.
- Decode, by opcode [31:26]:
  - 0x00 R-type, rd = result, selected by funct [5:0]:
    - 0x20 ADD: rs+rt.
    - 0x22 SUB: rs-rt.
    - 0x24 AND.
    - 0x25 OR.
    - 0x2A SLT: signed compare, result 1/0.
    - Any other funct is a NOP.
  - 0x08 ADDI: rt = rs + imm. MOVI is ADDI with rs=R0.
  - 0x09 SUBI: rt = rs - imm.
  - 0x23 LW: rt = data_memory[rs+imm].
  - 0x2B SW: data_memory[rs+imm] = rt.
  - 0x04 BEQ: if rs==rt, PC = PC+4+(imm<<2).
  - 0x05 BNE: if rs!=rt, PC = PC+4+(imm<<2).
  - 0x02 J: PC = {PC+4[31:28], target[25:0], 2'b00}.
  - 0x3F HALT: sets halted; PC holds.
  - Any other opcode is a NOP.
- Next PC: PC+4 unless a branch is taken or a jump executes. The update is registered on the clk edge.
- Halt:
  - While halted=1: PC frozen, no register or memory writes.
  - halted clears only on reset.
- Reset asserted mid-program: state clears immediately and fetch restarts at address 0 after release.

Optional Feature:
- Macro MIPS32_TRACE_EN.
- When defined: every retiring instruction prints, via simulation-only $display, the time, PC, instruction, and any register or memory write (index and value).
- When undefined: no trace code is compiled; function is identical.

Decomposition:
- Shared package mips32_pkg holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT;
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - an ALU-op enum.
- Natural sub-module: mips32_regfile, instantiated as register_file.
- Memories and control stay inline in the top.

Test Plan:
- Reset: hold reset=0, then release. PC=0, R0..R31=0, halted=0.
- Summation loop:
  - instr_mem[0..9] = 20030000, 2001000F, 20020005, 20210001, 8C240000, 00641820, 24420001, 10400001, 08000003, FC000000.
  - data_memory[16..20] = 8, 8, 9, 9, 10.
  - Required: R3=44, R1=20, R2=0, R4=10, halted=1, PC frozen at 0x24.
- Branch/jump targets:
  - BEQ R0,R0,+1 at PC 0x08 lands at PC 0x10.
  - J 3 lands at PC 0x0C.
  - A not-taken BNE lands at PC+4.
- R-type coverage: with R1=7 and R2=-3:
  - ADD gives 4, SUB gives 10, AND gives 5, OR gives -1, SLT R2,R1 gives 1.
  - A write to R0 leaves R0=0.
- Store/load: SW R5,4(R0) with R5=0x1234 → data_memory[4]=0x1234; a following LW R6,4(R0) → R6=0x1234.
- Halt then reset:
  - After HALT, 10 further clocks produce no state change.
  - Asserting reset=0 clears PC and halted; the program re-executes from 0.
